// File: rtl/pixel_group_writer.sv
// pixel_group_writer: serializes 8-pixel groups into raster-ordered framebuffer writes
module pixel_group_writer #(
    parameter int H_PIXELS = 256,
    parameter int V_PIXELS = 240,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [63:0]       group_in,
    input  logic              group_valid,
    output logic              group_ready,
    input  logic              sprite_0_hit,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    input  logic              fb_wait,
    output logic              sprite_0_hit_flag,
    output logic              frame_done,
    output logic              busy
);
    localparam int XW = $clog2(H_PIXELS);
    localparam int YW = $clog2(V_PIXELS);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t          state_q;
    logic [2:0]      lane_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [63:0]     shift_q;
    logic            flag_q;
    logic            done_q;
    logic            commit;
    logic            accept;
    logic            eol;
    logic            eof;
    // handshake and raster-wrap decode; a new group may load on the lane-0 commit
    always_comb begin
        commit      = (state_q == SHIFT) && !fb_wait;
        group_ready = !rst && !frame_start && ((state_q == IDLE) || (commit && lane_q == 3'd0));
        accept      = group_valid && group_ready;
        eol         = x_q == XW'(H_PIXELS - 1);
        eof         = eol && (y_q == YW'(V_PIXELS - 1));
    end
    assign fb_we             = state_q == SHIFT;
    assign busy              = state_q == SHIFT;
    assign fb_data           = shift_q[{lane_q, 3'b000} +: 8];
    assign fb_addr           = ADDR_W'(y_q) * ADDR_W'(H_PIXELS) + ADDR_W'(x_q);
    assign sprite_0_hit_flag = flag_q;
    assign frame_done        = done_q;
    // serializer FSM: lane 7 (leftmost pixel) first, raster advances on every commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= 3'd7;
            x_q     <= '0;
            y_q     <= '0;
            shift_q <= '0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (frame_start) begin
            state_q <= IDLE;
            lane_q  <= 3'd7;
            x_q     <= '0;
            y_q     <= '0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= commit && eof;
            if (commit) begin
                lane_q <= lane_q - 3'd1;
                x_q    <= eol ? '0 : x_q + 1'b1;
                y_q    <= eof ? '0 : (eol ? y_q + 1'b1 : y_q);
                if (lane_q == 3'd0)
                    state_q <= IDLE;
            end
            if (accept) begin
                shift_q <= group_in;
                lane_q  <= 3'd7;
                state_q <= SHIFT;
                flag_q  <= flag_q | sprite_0_hit;
            end
        end
    end
endmodule

// File: tb/tb_pixel_group_writer.sv
// tb_pixel_group_writer: directed checks of serialization, raster addressing, stalls and frame control
module tb_pixel_group_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [63:0] group_in = '0;
    logic        group_valid = 1'b0;
    logic        group_ready;
    logic        sprite_0_hit = 1'b0;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_wait = 1'b0;
    logic        sprite_0_hit_flag;
    logic        frame_done;
    logic        busy;
    int          errors = 0;
    int          checks = 0;

    pixel_group_writer dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .group_in(group_in),
        .group_valid(group_valid), .group_ready(group_ready), .sprite_0_hit(sprite_0_hit),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_wait(fb_wait),
        .sprite_0_hit_flag(sprite_0_hit_flag), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] mk(input int base);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(base + i);
        return r;
    endfunction

    initial begin
        int bad;
        int dones;
        int p;
        step();
        #1;
        check("rst_ready", group_ready, 0);
        check("rst_we", fb_we, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_data", fb_data, 0);
        check("rst_flag", sprite_0_hit_flag, 0);
        check("rst_done", frame_done, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", group_ready, 1);

        // single group
        group_in = 64'h0706050403020100;
        group_valid = 1'b1;
        step();
        group_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("g1_we", fb_we, 1);
            check("g1_busy", busy, 1);
            check("g1_addr", fb_addr, k);
            check("g1_data", fb_data, 7 - k);
            step();
        end
        #1;
        check("g1_idle_busy", busy, 0);
        check("g1_idle_we", fb_we, 0);
        check("g1_idle_ready", group_ready, 1);

        // 32 groups back-to-back crossing line 0 -> line 1
        group_in = mk(0);
        group_valid = 1'b1;
        step();
        for (int g = 0; g < 32; g++) begin
            for (int l = 7; l >= 0; l--) begin
                if (l == 0) begin
                    group_in = mk((g + 1) * 8);
                    group_valid = (g < 31);
                end
                #1;
                check("stream_we", fb_we, 1);
                check("stream_addr", fb_addr, 8 + g * 8 + 7 - l);
                check("stream_data", fb_data, (g * 8 + l) & 255);
                step();
            end
        end
        #1;
        check("stream_idle_we", fb_we, 0);
        check("stream_idle_ready", group_ready, 1);

        // 3-cycle stall on the third pixel
        group_in = 64'h1716151413121110;
        group_valid = 1'b1;
        step();
        group_valid = 1'b0;
        for (int k = 0; k < 11; k++) begin
            p = (k < 2) ? k : ((k < 5) ? 2 : k - 3);
            fb_wait = (k >= 2 && k < 5);
            #1;
            check("stall_we", fb_we, 1);
            check("stall_addr", fb_addr, 264 + p);
            check("stall_data", fb_data, 8'h17 - p);
            check("stall_ready", group_ready, k == 10);
            step();
        end
        fb_wait = 1'b0;
        #1;
        check("stall_idle", busy, 0);

        // sticky sprite-0 hit
        group_in = mk(48);
        group_valid = 1'b1;
        sprite_0_hit = 1'b1;
        #1;
        check("flag_before", sprite_0_hit_flag, 0);
        step();
        group_valid = 1'b0;
        sprite_0_hit = 1'b0;
        #1;
        check("flag_rise", sprite_0_hit_flag, 1);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                group_in = mk(64);
                group_valid = 1'b1;
            end
            #1;
            check("flag_hold", sprite_0_hit_flag, 1);
            check("hit_addr", fb_addr, 272 + k);
            step();
        end
        group_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("flag_sticky", sprite_0_hit_flag, 1);
            check("hit2_addr", fb_addr, 280 + k);
            check("hit2_data", fb_data, 64 + 7 - k);
            step();
        end

        // frame_start after 4 lanes, with a competing group
        group_in = mk(80);
        group_valid = 1'b1;
        step();
        group_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("fs_addr", fb_addr, 288 + k);
            check("fs_data", fb_data, 87 - k);
            step();
        end
        frame_start = 1'b1;
        group_valid = 1'b1;
        group_in = mk(96);
        #1;
        check("fs_ready", group_ready, 0);
        check("fs_flag_pre", sprite_0_hit_flag, 1);
        step();
        frame_start = 1'b0;
        group_valid = 1'b0;
        #1;
        check("fs_busy", busy, 0);
        check("fs_we", fb_we, 0);
        check("fs_flag_clear", sprite_0_hit_flag, 0);
        check("fs_no_done", frame_done, 0);
        check("fs_ready_after", group_ready, 1);
        step();
        #1;
        check("fs_no_tail", fb_we, 0);
        group_in = mk(112);
        group_valid = 1'b1;
        step();
        group_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("fs_next_addr", fb_addr, k);
            check("fs_next_data", fb_data, 119 - k);
            step();
        end

        // reset mid-group
        group_in = mk(128);
        group_valid = 1'b1;
        step();
        group_valid = 1'b0;
        #1;
        check("rmid_addr0", fb_addr, 8);
        step();
        #1;
        check("rmid_addr1", fb_addr, 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rmid_we", fb_we, 0);
        check("rmid_busy", busy, 0);
        check("rmid_addr", fb_addr, 0);
        step();
        #1;
        check("rmid_no_write", fb_we, 0);

        // full frame
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        group_in = mk(128);
        group_valid = 1'b1;
        step();
        bad = 0;
        dones = 0;
        for (int n = 0; n < 61440; n++) begin
            if (n % 8 == 7) group_valid = (n != 61439);
            #1;
            if (fb_we !== 1'b1 || fb_addr !== 16'(n) || fb_data !== 8'(128 + 7 - (n % 8))) bad++;
            if (frame_done !== 1'b0) dones++;
            if (n == 61439) check("last_addr", fb_addr, 16'hEFFF);
            step();
        end
        check("frame_contig", bad, 0);
        check("early_done", dones, 0);
        #1;
        check("frame_done", frame_done, 1);
        check("frame_end_we", fb_we, 0);
        step();
        #1;
        check("frame_done_once", frame_done, 0);
        group_in = 64'h0706050403020100;
        group_valid = 1'b1;
        step();
        group_valid = 1'b0;
        #1;
        check("next_frame_addr", fb_addr, 0);
        check("next_frame_data", fb_data, 7);
        check("next_frame_we", fb_we, 1);
        for (int k = 0; k < 8; k++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
